// File: rtl/stream_dot_product_if.sv
// Handshake bundle for stream_dot_product: header, operand-pair and result channels.
// master = streamer/consumer side, slave = dot-product lane.
interface stream_dot_product_if #(
   parameter int LEN_W = 9
);
   logic [LEN_W-1:0] input_len;
   logic [31:0]      input_bias;
   logic             input_hdr_stb;
   logic             input_hdr_ack;
   logic [31:0]      input_a;
   logic [31:0]      input_b;
   logic             input_ab_stb;
   logic             input_ab_ack;
   logic [31:0]      output_z;
   logic             output_z_stb;
   logic             output_z_ack;

   modport master (
      output input_len, input_bias, input_hdr_stb,
      input  input_hdr_ack,
      output input_a, input_b, input_ab_stb,
      input  input_ab_ack,
      input  output_z, output_z_stb,
      output output_z_ack
   );

   modport slave (
      input  input_len, input_bias, input_hdr_stb,
      output input_hdr_ack,
      input  input_a, input_b, input_ab_stb,
      output input_ab_ack,
      output output_z, output_z_stb,
      input  output_z_ack
   );
endinterface

// File: rtl/stream_dot_product.sv
// Streaming float32 dot product with bias and optional ReLU, one pair per handshake.
// Ports: clk, rst (sync, active-high), bus (header/pair/result channels), busy.

// Single-precision multiply/add unit with stb/ack handshakes.
// Denormal inputs and results are flushed to signed zero; rounding is nearest-even.
module sdp_fpu #(
   parameter bit IS_ADD = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic        a_stb,
   output logic        a_ack,
   input  logic [31:0] b,
   input  logic        b_stb,
   output logic        b_ack,
   output logic [31:0] z,
   output logic        z_stb,
   input  logic        z_ack
);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {U_GET, U_CALC, U_PUT} ustate_t;

   ustate_t     st;
   logic [31:0] a_r, b_r, res;
   logic        have_a, have_b;

   function automatic logic is_nan(input logic [31:0] x);
      return (&x[30:23]) && (|x[22:0]);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (&x[30:23]) && !(|x[22:0]);
   endfunction

   function automatic logic is_zero(input logic [31:0] x);
      return !(|x[30:23]);
   endfunction

   function automatic logic [31:0] rnd_pack(
      input logic              s,
      input logic signed [9:0] e_in,
      input logic [23:0]       r,
      input logic              g,
      input logic              sticky
   );
      logic signed [9:0] e;
      logic [24:0]       rr;
      logic              inc;
      e   = e_in;
      inc = g && (sticky || r[0]);
      rr  = {1'b0, r} + {24'b0, inc};
      if (rr[24]) begin
         rr = rr >> 1;
         e  = e + 10'sd1;
      end
      if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
      if (e <= 10'sd0) return {s, 31'b0};
      return {s, e[7:0], rr[22:0]};
   endfunction

   function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
      logic              s;
      logic [47:0]       m;
      logic signed [9:0] e;
      s = x[31] ^ y[31];
      if (is_nan(x) || is_nan(y)) return QNAN;
      if ((is_inf(x) && is_zero(y)) || (is_zero(x) && is_inf(y))) return QNAN;
      if (is_inf(x) || is_inf(y)) return {s, 8'hFF, 23'b0};
      if (is_zero(x) || is_zero(y)) return {s, 31'b0};
      m = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
      e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
      if (m[47])
         return rnd_pack(s, e + 10'sd1, m[47:24], m[23], |m[22:0]);
      return rnd_pack(s, e, m[46:23], m[22], |m[21:0]);
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]       big, sml;
      logic [26:0]       mb, ms, msh, mask, v;
      logic [27:0]       sum;
      logic [7:0]        d;
      logic signed [9:0] e;
      logic [4:0]        lz;
      logic              found;
      if (is_nan(x) || is_nan(y)) return QNAN;
      if (is_inf(x) && is_inf(y) && (x[31] != y[31])) return QNAN;
      if (is_inf(x)) return x;
      if (is_inf(y)) return y;
      if (is_zero(x) && is_zero(y)) return {x[31] & y[31], 31'b0};
      if (is_zero(x)) return y;
      if (is_zero(y)) return x;
      if (x[30:0] >= y[30:0]) begin
         big = x;
         sml = y;
      end else begin
         big = y;
         sml = x;
      end
      d  = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      // Bits shifted out of the small operand collapse into a sticky lsb.
      if (d > 8'd26) begin
         msh = 27'd1;
      end else begin
         mask = ~(27'h7FFFFFF << d);
         msh  = (ms >> d) | {26'b0, |(ms & mask)};
      end
      e = $signed({2'b0, big[30:23]});
      if (big[31] == sml[31]) begin
         sum = {1'b0, mb} + {1'b0, msh};
         if (sum[27]) begin
            v = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
         end else begin
            v = sum[26:0];
         end
      end else begin
         v = mb - msh;
         if (v == 27'd0) return 32'h0;
         lz    = 5'd0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
               lz    = 5'(26 - i);
               found = 1'b1;
            end
         end
         v = v << lz;
         e = e - $signed({5'b0, lz});
      end
      return rnd_pack(big[31], e, v[26:3], v[2], v[1] | v[0]);
   endfunction

   if (IS_ADD) begin : g_add
      assign res = fadd(a_r, b_r);
   end else begin : g_mul
      assign res = fmul(a_r, b_r);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= U_GET;
         a_ack  <= 1'b0;
         b_ack  <= 1'b0;
         z_stb  <= 1'b0;
         z      <= 32'h0;
         a_r    <= 32'h0;
         b_r    <= 32'h0;
         have_a <= 1'b0;
         have_b <= 1'b0;
      end else begin
         unique case (st)
            U_GET: begin
               if (!have_a) begin
                  if (a_ack && a_stb) begin
                     a_r    <= a;
                     have_a <= 1'b1;
                     a_ack  <= 1'b0;
                  end else begin
                     a_ack <= 1'b1;
                  end
               end
               if (!have_b) begin
                  if (b_ack && b_stb) begin
                     b_r    <= b;
                     have_b <= 1'b1;
                     b_ack  <= 1'b0;
                  end else begin
                     b_ack <= 1'b1;
                  end
               end
               if (have_a && have_b) st <= U_CALC;
            end
            U_CALC: begin
               z  <= res;
               st <= U_PUT;
            end
            U_PUT: begin
               if (!z_stb) begin
                  z_stb <= 1'b1;
               end else if (z_ack) begin
                  z_stb  <= 1'b0;
                  have_a <= 1'b0;
                  have_b <= 1'b0;
                  st     <= U_GET;
               end
            end
            default: st <= U_GET;
         endcase
      end
   end
endmodule

module stream_dot_product #(
   parameter int N_MAX   = 256,
   parameter int LEN_W   = $clog2(N_MAX + 1),
   parameter bit BIAS_EN = 1'b1,
   parameter bit RELU    = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   stream_dot_product_if.slave  bus,
   output logic                 busy
);
   typedef enum logic [2:0] {
      GET_HDR, GET_PAIR, MUL, ADD, PUT_Z
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len_r, count, len_clamp;
   logic [31:0]      acc, prod, a_r, b_r;
   logic             a_done, b_done;

   logic        mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack;
   logic        mul_z_stb, mul_z_ack;
   logic [31:0] mul_z;
   logic        add_a_stb, add_b_stb, add_a_ack, add_b_ack;
   logic        add_z_stb, add_z_ack;
   logic [31:0] add_z;

   assign len_clamp = (bus.input_len > LEN_W'(N_MAX)) ?
                      LEN_W'(N_MAX) : bus.input_len;

   sdp_fpu #(.IS_ADD(1'b0)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .a     (a_r),
      .a_stb (mul_a_stb),
      .a_ack (mul_a_ack),
      .b     (b_r),
      .b_stb (mul_b_stb),
      .b_ack (mul_b_ack),
      .z     (mul_z),
      .z_stb (mul_z_stb),
      .z_ack (mul_z_ack)
   );

   sdp_fpu #(.IS_ADD(1'b1)) u_add (
      .clk   (clk),
      .rst   (rst),
      .a     (acc),
      .a_stb (add_a_stb),
      .a_ack (add_a_ack),
      .b     (prod),
      .b_stb (add_b_stb),
      .b_ack (add_b_ack),
      .z     (add_z),
      .z_stb (add_z_stb),
      .z_ack (add_z_ack)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= GET_HDR;
         bus.input_hdr_ack <= 1'b0;
         bus.input_ab_ack  <= 1'b0;
         bus.output_z_stb  <= 1'b0;
         bus.output_z      <= 32'h0;
         busy              <= 1'b0;
         len_r             <= '0;
         count             <= '0;
         acc               <= 32'h0;
         prod              <= 32'h0;
         a_r               <= 32'h0;
         b_r               <= 32'h0;
         a_done            <= 1'b0;
         b_done            <= 1'b0;
         mul_a_stb         <= 1'b0;
         mul_b_stb         <= 1'b0;
         mul_z_ack         <= 1'b0;
         add_a_stb         <= 1'b0;
         add_b_stb         <= 1'b0;
         add_z_ack         <= 1'b0;
      end else begin
         unique case (state)
            GET_HDR: begin
               if (!bus.input_hdr_ack) begin
                  bus.input_hdr_ack <= 1'b1;
               end else if (bus.input_hdr_stb) begin
                  bus.input_hdr_ack <= 1'b0;
                  len_r             <= len_clamp;
                  acc               <= BIAS_EN ? bus.input_bias : 32'h0;
                  count             <= '0;
                  busy              <= 1'b1;
                  state <= (len_clamp == '0) ? PUT_Z : GET_PAIR;
               end
            end
            GET_PAIR: begin
               if (!bus.input_ab_ack) begin
                  bus.input_ab_ack <= 1'b1;
               end else if (bus.input_ab_stb) begin
                  bus.input_ab_ack <= 1'b0;
                  a_r              <= bus.input_a;
                  b_r              <= bus.input_b;
                  mul_a_stb        <= 1'b1;
                  mul_b_stb        <= 1'b1;
                  state            <= MUL;
               end
            end
            MUL: begin
               if (mul_a_stb && mul_a_ack) begin
                  mul_a_stb <= 1'b0;
                  a_done    <= 1'b1;
               end
               if (mul_b_stb && mul_b_ack) begin
                  mul_b_stb <= 1'b0;
                  b_done    <= 1'b1;
               end
               if (a_done && b_done) begin
                  if (mul_z_ack && mul_z_stb) begin
                     mul_z_ack <= 1'b0;
                     prod      <= mul_z;
                     a_done    <= 1'b0;
                     b_done    <= 1'b0;
                     add_a_stb <= 1'b1;
                     add_b_stb <= 1'b1;
                     state     <= ADD;
                  end else begin
                     mul_z_ack <= 1'b1;
                  end
               end
            end
            ADD: begin
               if (add_a_stb && add_a_ack) begin
                  add_a_stb <= 1'b0;
                  a_done    <= 1'b1;
               end
               if (add_b_stb && add_b_ack) begin
                  add_b_stb <= 1'b0;
                  b_done    <= 1'b1;
               end
               if (a_done && b_done) begin
                  if (add_z_ack && add_z_stb) begin
                     add_z_ack <= 1'b0;
                     acc       <= add_z;
                     count     <= count + LEN_W'(1);
                     a_done    <= 1'b0;
                     b_done    <= 1'b0;
                     state <= (count + LEN_W'(1) == len_r) ? PUT_Z : GET_PAIR;
                  end else begin
                     add_z_ack <= 1'b1;
                  end
               end
            end
            PUT_Z: begin
               if (!bus.output_z_stb) begin
                  bus.output_z     <= (RELU && acc[31]) ? 32'h0 : acc;
                  bus.output_z_stb <= 1'b1;
               end else if (bus.output_z_ack) begin
                  bus.output_z_stb <= 1'b0;
                  busy             <= 1'b0;
                  state            <= GET_HDR;
               end
            end
            default: state <= GET_HDR;
         endcase
      end
   end
endmodule

// File: tb/tb_stream_dot_product.sv
// Directed bench for stream_dot_product: three lanes (plain, ReLU, no-bias) in lockstep.
// Lanes share stimulus; handshake timing is checked on the plain lane.
module tb_stream_dot_product;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy0, busy1, busy2;

   logic [LW-1:0] len     = '0;
   logic [31:0]   bias    = '0;
   logic          hdr_stb = 1'b0;
   logic [31:0]   a       = '0;
   logic [31:0]   b       = '0;
   logic          ab_stb  = 1'b0;
   logic          z_ack   = 1'b0;

   int checks = 0;
   int passed = 0;
   int mul_cnt = 0;
   int ab_cnt = 0;
   int zst_cnt = 0;

   logic [31:0] z0, z1, z2, zc;
   int n, m0, ab0, zs0;

   stream_dot_product_if #(.LEN_W(LW)) if0 ();
   stream_dot_product_if #(.LEN_W(LW)) if1 ();
   stream_dot_product_if #(.LEN_W(LW)) if2 ();

   assign if0.input_len = len;     assign if1.input_len = len;     assign if2.input_len = len;
   assign if0.input_bias = bias;   assign if1.input_bias = bias;   assign if2.input_bias = bias;
   assign if0.input_hdr_stb = hdr_stb;
   assign if1.input_hdr_stb = hdr_stb;
   assign if2.input_hdr_stb = hdr_stb;
   assign if0.input_a = a;         assign if1.input_a = a;         assign if2.input_a = a;
   assign if0.input_b = b;         assign if1.input_b = b;         assign if2.input_b = b;
   assign if0.input_ab_stb = ab_stb;
   assign if1.input_ab_stb = ab_stb;
   assign if2.input_ab_stb = ab_stb;
   assign if0.output_z_ack = z_ack;
   assign if1.output_z_ack = z_ack;
   assign if2.output_z_ack = z_ack;

   stream_dot_product #(.N_MAX(8), .LEN_W(LW), .BIAS_EN(1'b1), .RELU(1'b0)) u0 (
      .clk(clk), .rst(rst), .bus(if0), .busy(busy0));
   stream_dot_product #(.N_MAX(8), .LEN_W(LW), .BIAS_EN(1'b1), .RELU(1'b1)) u1 (
      .clk(clk), .rst(rst), .bus(if1), .busy(busy1));
   stream_dot_product #(.N_MAX(8), .LEN_W(LW), .BIAS_EN(1'b0), .RELU(1'b0)) u2 (
      .clk(clk), .rst(rst), .bus(if2), .busy(busy2));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (u0.mul_a_stb || u0.mul_b_stb) mul_cnt <= mul_cnt + 1;
      if (if0.input_ab_stb && if0.input_ab_ack) ab_cnt <= ab_cnt + 1;
      if (if0.output_z_stb) zst_cnt <= zst_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic send_hdr(input logic [LW-1:0] l, input logic [31:0] bi);
      int k = 0;
      len = l; bias = bi; hdr_stb = 1'b1;
      while (!if0.input_hdr_ack && k < 200) begin
         @(negedge clk); k++;
      end
      chk("hdr_timeout", {31'b0, k < 200}, 32'd1);
      @(posedge clk); #1 hdr_stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_pair(input logic [31:0] x, input logic [31:0] y);
      int k = 0;
      a = x; b = y; ab_stb = 1'b1;
      while (!if0.input_ab_ack && k < 200) begin
         @(negedge clk); k++;
      end
      chk("ab_timeout", {31'b0, k < 200}, 32'd1);
      @(posedge clk); #1 ab_stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic get_z();
      int k = 0;
      z_ack = 1'b1;
      while (!if0.output_z_stb && k < 400) begin
         @(negedge clk); k++;
      end
      chk("z_timeout", {31'b0, k < 400}, 32'd1);
      z0 = if0.output_z; z1 = if1.output_z; z2 = if2.output_z;
      @(posedge clk); #1 z_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hdr_ack", {31'b0, if0.input_hdr_ack}, 32'd0);
      chk("rst_ab_ack", {31'b0, if0.input_ab_ack}, 32'd0);
      chk("rst_z_stb", {31'b0, if0.output_z_stb}, 32'd0);
      chk("rst_z", if0.output_z, 32'h0);
      chk("rst_busy", {31'b0, busy0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // ((0.5 + 1*4) + 2*5) + 3*6 = 32.5
      send_hdr(4'd3, 32'h3F000000);
      chk("busy_run", {31'b0, busy0}, 32'd1);
      send_pair(32'h3F800000, 32'h40800000);
      send_pair(32'h40000000, 32'h40A00000);
      send_pair(32'h40400000, 32'h40C00000);
      get_z();
      chk("dot3_z", z0, 32'h42020000);
      chk("dot3_relu", z1, 32'h42020000);
      chk("dot3_nobias", z2, 32'h42000000);
      chk("dot3_busy", {31'b0, busy0}, 32'd0);

      // -1.5 * 2.0 = -3.0, held under backpressure with a header pending
      send_hdr(4'd1, 32'h0);
      send_pair(32'hBFC00000, 32'h40000000);
      len = 4'd0; bias = 32'hC0000000; hdr_stb = 1'b1;
      n = 0;
      while (!if0.output_z_stb && n < 400) begin
         @(negedge clk); n++;
      end
      chk("neg_timeout", {31'b0, n < 400}, 32'd1);
      zc = if0.output_z;
      chk("neg_z", zc, 32'hC0400000);
      chk("neg_relu", if1.output_z, 32'h0);
      chk("neg_nobias", if2.output_z, 32'hC0400000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_stb", {31'b0, if0.output_z_stb}, 32'd1);
         chk("bp_z", if0.output_z, zc);
         chk("bp_hdr_ack", {31'b0, if0.input_hdr_ack}, 32'd0);
      end
      z_ack = 1'b1;
      @(posedge clk); #1 z_ack = 1'b0;
      n = 0;
      @(negedge clk);
      while (!if0.input_hdr_ack && n < 5) begin
         @(negedge clk); n++;
      end
      chk("hdr_after_bp", {31'b0, n <= 1}, 32'd1);
      @(posedge clk); #1 hdr_stb = 1'b0;
      @(negedge clk);

      // len=0: bias straight through, multiplier untouched
      m0 = mul_cnt;
      get_z();
      chk("len0_z", z0, 32'hC0000000);
      chk("len0_relu", z1, 32'h0);
      chk("len0_nobias", z2, 32'h0);
      chk("len0_no_mul", mul_cnt - m0, 32'd0);

      // len=15 clamps to 8; the 9th pair waits for the next header
      ab0 = ab_cnt;
      send_hdr(4'd15, 32'h0);
      for (int i = 0; i < 8; i++) send_pair(32'h3F800000, 32'h3F800000);
      a = 32'h40000000; b = 32'h40400000; ab_stb = 1'b1;
      get_z();
      chk("clamp_z", z0, 32'h41000000);
      chk("clamp_nobias", z2, 32'h41000000);
      chk("clamp_ab_cnt", ab_cnt - ab0, 32'd8);
      repeat (3) @(negedge clk);
      chk("clamp_ab_hold", ab_cnt - ab0, 32'd8);
      chk("clamp_ab_ack", {31'b0, if0.input_ab_ack}, 32'd0);
      send_hdr(4'd1, 32'h0);
      send_pair(32'h40000000, 32'h40400000);
      chk("ninth_ab_cnt", ab_cnt - ab0, 32'd9);
      get_z();
      chk("ninth_z", z0, 32'h40C00000);
      chk("ninth_relu", z1, 32'h40C00000);

      // Reset after 2 of 4 pairs discards the partial sum
      send_hdr(4'd4, 32'h3F000000);
      send_pair(32'h3F800000, 32'h3F800000);
      send_pair(32'h3F800000, 32'h3F800000);
      zs0 = zst_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", {31'b0, busy0}, 32'd0);
      chk("mid_rst_ab_ack", {31'b0, if0.input_ab_ack}, 32'd0);
      chk("mid_rst_hdr_ack", {31'b0, if0.input_hdr_ack}, 32'd0);
      rst = 1'b0;
      send_hdr(4'd1, 32'h0);
      send_pair(32'h40000000, 32'h40400000);
      chk("mid_rst_no_z", zst_cnt - zs0, 32'd0);
      get_z();
      chk("post_rst_z", z0, 32'h40C00000);
      chk("post_rst_relu", z1, 32'h40C00000);
      chk("post_rst_nobias", z2, 32'h40C00000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/stream_dot_product.md
Name: stream_dot_product

Overview:
- Streaming float32 inner product with bias and optional ReLU. It is the successor to the fixed-width vector-in inner product.
- Operand pairs arrive one per handshake, so the vector length is a runtime value bounded only by N_MAX, not by port width.
- Uses one existing multiplier and one existing adder (IEEE-754 single, stb/ack handshakes).
- Sits between the weight/activation streamers and the layer output buffer; one instance per neuron lane.

Parameters:
- N_MAX, 256: maximum elements per vector; a requested length above it is clamped.
- LEN_W, $clog2(N_MAX+1): width of the length field.
- BIAS_EN, 1: 1 means the accumulator starts from input_bias; 0 means it starts from +0.0 and input_bias is ignored.
- RELU, 0: 1 means a result with sign bit set is output as 32'h00000000.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- input_len  in  LEN_W  element count for next vector
- input_bias  in  32  float32 bias for next vector
- input_hdr_stb  in  1  header (len, bias) valid
- input_hdr_ack  out  1  header accepted
- input_a  in  32  float32 operand a
- input_b  in  32  float32 operand b
- input_ab_stb  in  1  operand pair valid
- input_ab_ack  out  1  operand pair accepted
- output_z  out  32  float32 result
- output_z_stb  out  1  result valid
- output_z_ack  in  1  result consumed
- busy  out  1  high in every state except GET_HDR

Behaviour:
- Handshakes:
  - A transfer occurs on a rising edge where stb and ack are both high.
  - Our ack/stb outputs are registered. They are asserted starting the cycle after entering the waiting state and cleared the cycle after the transfer.
  - At most one transfer per channel per two cycles.
  - output_z and output_z_stb hold stable until the transfer.
- Reset: input_hdr_ack=0, input_ab_ack=0, output_z_stb=0, output_z=0, busy=0, state=GET_HDR. Internal sub-unit stb/ack=0, count=0, acc=0. The multiplier and adder share rst.
- States:
  - GET_HDR:
    - Assert input_hdr_ack.
    - On transfer: len_r = min(input_len, N_MAX); acc = BIAS_EN ? input_bias : 32'h0; count = 0.
    - If len_r==0, go to PUT_Z; otherwise go to GET_PAIR.
  - GET_PAIR: assert input_ab_ack. On transfer, latch a and b, then go to MUL.
  - MUL:
    - Drive the multiplier's a_stb and b_stb independently. Each is cleared on its own ack; track done flags.
    - Then raise the multiplier's z_ack. On z transfer, latch prod and go to ADD.
  - ADD:
    - Same protocol on the adder with inputs a=acc, b=prod.
    - On z transfer: acc = sum; count = count+1.
    - If count+1 == len_r, go to PUT_Z; otherwise go to GET_PAIR.
  - PUT_Z:
    - Register output_z = (RELU && acc[31]) ? 32'h0 : acc and assert output_z_stb.
    - On transfer, go to GET_HDR.
- Latency: the result is the data-dependent sum of multiplier and adder latencies per element, plus handshake overhead. No fixed cycle count is required; ordering and values are required.
- Accumulation is strictly sequential in index order: ((bias+p0)+p1)+...; a bench compares against this order bit-exactly.
- Width and count rules:
  - count is LEN_W bits and never wraps, because len_r <= N_MAX.
  - len clamping is silent. Pairs beyond len_r belong to the next vector and are not acked until after the next header.
- len_r==0: no multiplier or adder activity; the output is bias (or +0.0), with ReLU applied.
- ReLU and special values: ReLU tests only bit 31, so -0.0 and negative NaN both map to +0.0. Inf/NaN otherwise propagate per the adder and multiplier.
- Simultaneous events:
  - A header presented while busy is not acked.
  - input_ab_stb while in GET_HDR is not acked.
  - output_z_ack while output_z_stb is low has no effect.
- Reset mid-operation:
  - Any state returns to GET_HDR next cycle; the partial accumulator is discarded.
  - No output_z_stb pulse occurs; acks drop the cycle after rst is sampled.
- Backpressure: while output_z_ack is low in PUT_Z, the block stays in PUT_Z and no header is accepted.

Test Plan:
- BIAS_EN=1, header len=3, bias 0x3F000000 (0.5); pairs (1,4),(2,5),(3,6) as float32 -> one output 0x42020000 (32.5), then busy=0.
- len=0, bias 0xC0000000 (-2.0) -> RELU=0 gives output 0xC0000000 with no multiplier stb ever raised; RELU=1 gives 0x00000000.
- len=1, bias 0, a=0xBFC00000 (-1.5), b=0x40000000 (2.0) -> RELU=0 gives 0xC0400000; RELU=1 gives 0x00000000.
- N_MAX=8, len=15, 9 pairs streamed -> exactly 8 ab transfers, then result. The 9th pair stays unacked until a new header is accepted.
- Hold output_z_ack low 10 cycles with a second header pending -> output_z and output_z_stb stable for all 10 cycles, input_hdr_ack stays 0; after ack, header accepted within 2 cycles.
- Assert rst for 1 cycle after 2 of 4 pairs, then header len=1 bias 0, pair (2.0, 3.0) -> no output before reset recovery; single output 0x40C00000 (6.0).
